pipe_stage_skid: RTL and testbench

//  Parametrised pipeline stage register that replaces the fixed-field, enable-only stage registers.

---
 rtl/pipe_stage_skid.sv | 109 ++++++++++
 tb/tb_pipe_stage_skid.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer, valid/ready handshake,
// synchronous flush and a saturating stall-cycle counter.
module pipe_stage_skid #(
    parameter int DATA_W     = 32,
    parameter int EXC_W      = 5,
    parameter int CNT_W      = 16,
    parameter int CLEAR_DATA = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_exc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [EXC_W-1:0]  out_exc,
    output logic              exc_any,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_r;
    logic [DATA_W-1:0] main_data_r;
    logic [EXC_W-1:0]  main_exc_r;
    logic [DATA_W-1:0] skid_data_r;
    logic [EXC_W-1:0]  skid_exc_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic              accept_s;
    logic              pop_s;

    // The FULL term comes straight from the state register, so downstream
    // stalls never reach upstream combinationally.
    assign in_ready  = (state_r != ST_FULL) & ~reset & ~flush;
    assign out_valid = (state_r != ST_EMPTY);
    assign accept_s  = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;
    assign out_data  = main_data_r;
    assign out_exc   = main_exc_r;
    assign stall_cnt = stall_cnt_r;
    assign exc_any   = ((state_r != ST_EMPTY) & (|main_exc_r))
                     | ((state_r == ST_FULL)  & (|skid_exc_r));

    // Occupancy state machine and main/skid entry storage.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_r <= ST_EMPTY;
            if (CLEAR_DATA != 0) begin
                main_data_r <= {DATA_W{1'b0}};
                main_exc_r  <= {EXC_W{1'b0}};
                skid_data_r <= {DATA_W{1'b0}};
                skid_exc_r  <= {EXC_W{1'b0}};
            end
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_data_r <= in_data;
                        main_exc_r  <= in_exc;
                        state_r     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept_s && pop_s) begin
                        main_data_r <= in_data;
                        main_exc_r  <= in_exc;
                    end else if (accept_s) begin
                        skid_data_r <= in_data;
                        skid_exc_r  <= in_exc;
                        state_r     <= ST_FULL;
                    end else if (pop_s) begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop_s) begin
                        main_data_r <= skid_data_r;
                        main_exc_r  <= skid_exc_r;
                        state_r     <= ST_ONE;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

    // Saturating stall counter; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid && !out_ready && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, backpressure, flush,
// exception tracking and stall counter saturation (second instance, CNT_W=4).
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_exc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_exc;
    logic        exc_any;
    logic [15:0] stall_cnt;

    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] out_data4;
    logic [4:0]  out_exc4;
    logic        exc_any4;
    logic [3:0]  stall_cnt4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_exc(in_exc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_exc(out_exc),
        .exc_any(exc_any), .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .in_exc(in_exc),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_exc(out_exc4),
        .exc_any(exc_any4), .stall_cnt(stall_cnt4)
    );

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] d;
        logic [4:0]  e;
        logic        pre_rdy;
        logic        ov;
        logic        ir;
        logic [31:0] od;
        logic [4:0]  oe;
        logic        ea;
        logic [15:0] sc;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        flush    = 1'b0;
        in_data  = 32'h0;
        in_exc   = 5'd0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_data = 32'hDEAD_BEEF; in_exc = 5'd7;

        // Reset held two cycles with in_valid asserted.
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check("rst_out_valid", {31'h0, out_valid}, 32'h0);
            check("rst_in_ready", {31'h0, in_ready}, 32'h0);
            check("rst_out_data", out_data, 32'h0);
            check("rst_exc_any", {31'h0, exc_any}, 32'h0);
            check("rst_stall", {16'h0, stall_cnt}, 32'h0);
        end
        reset = 1'b0;
        idle_inputs();
        #1;
        check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

        // Streaming 0x10..0x1F with out_ready high.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h10 + 32'(i);
            #1;
            check("stream_in_ready", {31'h0, in_ready}, 32'h1);
            @(posedge clk); #1;
            check("stream_out_valid", {31'h0, out_valid}, 32'h1);
            check("stream_out_data", out_data, 32'h10 + 32'(i));
        end
        idle_inputs();
        @(posedge clk); #1;
        check("stream_drain", {31'h0, out_valid}, 32'h0);
        check("stream_stall", {16'h0, stall_cnt}, 32'h0);

        //          iv    ordy  fl    d             e     pre   ov    ir    od            oe    ea    sc
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'hAAAA0001, 5'd0, 1'b1, 1'b1, 1'b1, 32'hAAAA0001, 5'd0, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'hBBBB0002, 5'd0, 1'b1, 1'b1, 1'b0, 32'hAAAA0001, 5'd0, 1'b0, 16'd1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 1'b0, 1'b1, 1'b0, 32'hAAAA0001, 5'd0, 1'b0, 16'd2};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 1'b0, 1'b1, 1'b0, 32'hAAAA0001, 5'd0, 1'b0, 16'd3};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 1'b1, 1'b1, 32'hBBBB0002, 5'd0, 1'b0, 16'd3};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,        5'd0, 1'b1, 1'b0, 1'b1, 32'hBBBB0002, 5'd0, 1'b0, 16'd3};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h11111111, 5'd0, 1'b1, 1'b1, 1'b1, 32'h11111111, 5'd0, 1'b0, 16'd3};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h22222222, 5'd0, 1'b1, 1'b1, 1'b0, 32'h11111111, 5'd0, 1'b0, 16'd4};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'h0000000C, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0,        5'd0, 1'b0, 16'd4};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 1'b1, 1'b0, 1'b1, 32'h0,        5'd0, 1'b0, 16'd4};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h5,        5'd4, 1'b1, 1'b1, 1'b1, 32'h5,        5'd4, 1'b1, 16'd4};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h6,        5'd0, 1'b1, 1'b1, 1'b0, 32'h5,        5'd4, 1'b1, 16'd5};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 1'b1, 1'b1, 32'h6,        5'd0, 1'b0, 16'd5};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0,        5'd0, 1'b1, 1'b0, 1'b1, 32'h6,        5'd0, 1'b0, 16'd5};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h7,        5'd0, 1'b1, 1'b1, 1'b1, 32'h7,        5'd0, 1'b0, 16'd5};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h8,        5'd3, 1'b1, 1'b1, 1'b0, 32'h7,        5'd0, 1'b1, 16'd6};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 32'h0,        5'd0, 1'b0, 1'b0, 1'b1, 32'h0,        5'd0, 1'b0, 16'd7};

        foreach (vecs[k]) begin
            in_valid  = vecs[k].iv;
            out_ready = vecs[k].ordy;
            flush     = vecs[k].fl;
            in_data   = vecs[k].d;
            in_exc    = vecs[k].e;
            #1;
            check($sformatf("v%0d_pre_ready", k), {31'h0, in_ready}, {31'h0, vecs[k].pre_rdy});
            @(posedge clk); #1;
            idle_inputs();
            #1;
            check($sformatf("v%0d_out_valid", k), {31'h0, out_valid}, {31'h0, vecs[k].ov});
            check($sformatf("v%0d_in_ready", k), {31'h0, in_ready}, {31'h0, vecs[k].ir});
            check($sformatf("v%0d_out_data", k), out_data, vecs[k].od);
            check($sformatf("v%0d_out_exc", k), {27'h0, out_exc}, {27'h0, vecs[k].oe});
            check($sformatf("v%0d_exc_any", k), {31'h0, exc_any}, {31'h0, vecs[k].ea});
            check($sformatf("v%0d_stall", k), {16'h0, stall_cnt}, {16'h0, vecs[k].sc});
        end

        // Saturation: one word held for 20 stall cycles.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0;
        @(posedge clk); #1;
        idle_inputs();
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            check("sat_stall4", {28'h0, stall_cnt4}, (k > 15) ? 32'd15 : 32'(k));
        end
        check("sat_stall16", {16'h0, stall_cnt}, 32'd20);
        check("sat_out_valid4", {31'h0, out_valid4}, 32'h1);
        check("sat_out_data4", out_data4, 32'h55);
        check("sat_out_exc4", {27'h0, out_exc4}, 32'h0);
        check("sat_exc_any4", {31'h0, exc_any4}, 32'h0);
        check("sat_in_ready4", {31'h0, in_ready4}, 32'h1);

        // Reset mid-transfer wins over accept and flush.
        reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 32'h99; in_exc = 5'd2;
        @(posedge clk); #1;
        check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_out_data", out_data, 32'h0);
        check("midrst_stall", {16'h0, stall_cnt}, 32'h0);
        check("midrst_stall4", {28'h0, stall_cnt4}, 32'h0);
        check("midrst_exc_any", {31'h0, exc_any}, 32'h0);
        reset = 1'b0;
        idle_inputs();
        #1;
        check("midrst_in_ready", {31'h0, in_ready}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
